// File: rtl/rob_core_if.sv
// Bundle of the rob <-> renaming / writeback / commit signals.
// master: renaming, execute and commit side. slave: the ROB.
interface rob_core_if #(
   parameter int MACHINE_WIDTH = 2,
   parameter int ROB_DEPTH     = 16,
   parameter int FU_NUM        = 4,
   parameter int PREG_W        = 6
);
   localparam int AW = $clog2(ROB_DEPTH);

   logic [MACHINE_WIDTH-1:0]        alloc_valid;
   logic [MACHINE_WIDTH*PREG_W-1:0] alloc_dst;
   logic [MACHINE_WIDTH*32-1:0]     alloc_pc;
   logic                            alloc_ready;
   logic [MACHINE_WIDTH*AW-1:0]     rob_addr;
   logic [FU_NUM-1:0]               wb_valid;
   logic [FU_NUM*AW-1:0]            wb_addr;
   logic [FU_NUM-1:0]               wb_exc;
   logic [MACHINE_WIDTH-1:0]        commit_valid;
   logic [MACHINE_WIDTH*PREG_W-1:0] commit_dst;
   logic [MACHINE_WIDTH*32-1:0]     commit_pc;
   logic [MACHINE_WIDTH-1:0]        commit_exc;

   modport master (
      output alloc_valid, alloc_dst, alloc_pc, wb_valid, wb_addr, wb_exc,
      input  alloc_ready, rob_addr, commit_valid, commit_dst, commit_pc, commit_exc
   );

   modport slave (
      input  alloc_valid, alloc_dst, alloc_pc, wb_valid, wb_addr, wb_exc,
      output alloc_ready, rob_addr, commit_valid, commit_dst, commit_pc, commit_exc
   );
endinterface

// File: rtl/rob_core.sv
// Reorder buffer: in-order allocation, out-of-order completion, in-order commit.
// Optional ROB_PERF_CNT_EN adds commit / full-stall / flush performance counters.
module rob_core #(
   parameter int MACHINE_WIDTH = 2,
   parameter int ROB_DEPTH     = 16,
   parameter int FU_NUM        = 4,
   parameter int PREG_W        = 6,
   localparam int AW           = $clog2(ROB_DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   rob_core_if.slave   bus,
   output logic [AW:0] count
`ifdef ROB_PERF_CNT_EN
   ,
   output logic [31:0] perf_commit_cnt,
   output logic [31:0] perf_full_stall,
   output logic [31:0] perf_flush_cnt
`endif
);

   logic [AW:0]          head, tail;
   logic [ROB_DEPTH-1:0] busy, done, exc;
   logic [PREG_W-1:0]    dst_q [ROB_DEPTH];
   logic [31:0]          pc_q  [ROB_DEPTH];
   logic [AW-1:0]        alloc_idx  [MACHINE_WIDTH];
   logic [AW-1:0]        commit_idx [MACHINE_WIDTH];
   logic [AW:0]          alloc_n, commit_n;
   logic                 fire;

   assign count           = tail - head;
   assign bus.alloc_ready = (ROB_DEPTH - int'(count)) >= MACHINE_WIDTH;
   assign fire            = (|bus.alloc_valid) && bus.alloc_ready && !flush;

   // Lanes are compacted: each lane takes tail plus the number of valid lanes below it.
   always_comb begin
      alloc_n = '0;
      for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
         alloc_idx[i] = tail[AW-1:0] + alloc_n[AW-1:0];
         bus.rob_addr[i*AW +: AW] = alloc_idx[i];
         if (bus.alloc_valid[i]) alloc_n = alloc_n + (AW+1)'(1);
      end
   end

   // The chain stops after an exception entry so it retires as the last lane.
   always_comb begin
      logic chain;
      chain    = 1'b1;
      commit_n = '0;
      for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
         commit_idx[i] = head[AW-1:0] + AW'(i);
         chain = chain & busy[commit_idx[i]] & done[commit_idx[i]];
         bus.commit_valid[i]                = chain;
         bus.commit_exc[i]                  = chain & exc[commit_idx[i]];
         bus.commit_dst[i*PREG_W +: PREG_W] = dst_q[commit_idx[i]];
         bus.commit_pc[i*32 +: 32]          = pc_q[commit_idx[i]];
         if (chain) commit_n = commit_n + (AW+1)'(1);
         chain = chain & ~exc[commit_idx[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head <= '0;
         tail <= '0;
         busy <= '0;
         done <= '0;
         exc  <= '0;
      end else begin
         for (int unsigned k = 0; k < FU_NUM; k++) begin
            if (bus.wb_valid[k] && busy[bus.wb_addr[k*AW +: AW]]) begin
               done[bus.wb_addr[k*AW +: AW]] <= 1'b1;
               if (bus.wb_exc[k]) exc[bus.wb_addr[k*AW +: AW]] <= 1'b1;
            end
         end
         for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            if (bus.commit_valid[i]) begin
               busy[commit_idx[i]] <= 1'b0;
               done[commit_idx[i]] <= 1'b0;
               exc[commit_idx[i]]  <= 1'b0;
            end
         end
         if (fire) begin
            for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
               if (bus.alloc_valid[i]) begin
                  busy[alloc_idx[i]] <= 1'b1;
                  done[alloc_idx[i]] <= 1'b0;
                  exc[alloc_idx[i]]  <= 1'b0;
               end
            end
            tail <= tail + alloc_n;
         end
         head <= head + commit_n;
      end
   end

   always_ff @(posedge clk) begin
      if (fire) begin
         for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            if (bus.alloc_valid[i]) begin
               dst_q[alloc_idx[i]] <= bus.alloc_dst[i*PREG_W +: PREG_W];
               pc_q[alloc_idx[i]]  <= bus.alloc_pc[i*32 +: 32];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && fire) begin
         for (int unsigned k = 0; k < FU_NUM; k++) begin
            for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
               if (bus.wb_valid[k] && bus.alloc_valid[i]) begin
                  wb_alloc_clash: assert (bus.wb_addr[k*AW +: AW] != alloc_idx[i])
                     else $error("writeback port %0d hits entry being allocated", k);
               end
            end
         end
      end
   end

`ifdef ROB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_commit_cnt <= '0;
         perf_full_stall <= '0;
         perf_flush_cnt  <= '0;
      end else begin
         perf_commit_cnt <= perf_commit_cnt + 32'(commit_n);
         if ((|bus.alloc_valid) && !bus.alloc_ready) perf_full_stall <= perf_full_stall + 32'd1;
         if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rob_core.sv
// Directed self-checking bench for rob_core: fill, out-of-order writeback,
// exception isolation, pointer wrap and flush.
module tb_rob_core;
   localparam int MW = 2;
   localparam int RD = 16;
   localparam int FN = 4;
   localparam int PW = 6;
   localparam int AW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [AW:0] count;
`ifdef ROB_PERF_CNT_EN
   logic [31:0] perf_commit_cnt, perf_full_stall, perf_flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int seq      = 0;
   int base;

   rob_core_if #(.MACHINE_WIDTH(MW), .ROB_DEPTH(RD), .FU_NUM(FN), .PREG_W(PW)) bus ();

   rob_core #(.MACHINE_WIDTH(MW), .ROB_DEPTH(RD), .FU_NUM(FN), .PREG_W(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus),
      .count (count)
`ifdef ROB_PERF_CNT_EN
      ,
      .perf_commit_cnt (perf_commit_cnt),
      .perf_full_stall (perf_full_stall),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pc_of(input int n);
      return 32'h1000 + 32'(n) * 32'd4;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_alloc(input logic [1:0] v, input bit adv);
      int s;
      s = seq;
      bus.alloc_valid = v;
      for (int i = 0; i < MW; i++) begin
         if (v[i]) begin
            bus.alloc_dst[i*PW +: PW] = PW'(s);
            bus.alloc_pc[i*32 +: 32]  = pc_of(s);
            s++;
         end else begin
            bus.alloc_dst[i*PW +: PW] = '0;
            bus.alloc_pc[i*32 +: 32]  = '0;
         end
      end
      if (adv) seq = s;
   endtask

   task automatic set_wb(input int port, input int addr, input bit e);
      bus.wb_valid[port]          = 1'b1;
      bus.wb_addr[port*AW +: AW]  = AW'(addr);
      bus.wb_exc[port]            = e;
   endtask

   task automatic clear_wb;
      bus.wb_valid = '0;
      bus.wb_addr  = '0;
      bus.wb_exc   = '0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      set_alloc(2'b00, 1'b0);
      clear_wb();
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_eq("reset_count", count, 0);
      check_eq("reset_ready", bus.alloc_ready, 1);
      check_eq("reset_commit", bus.commit_valid, 0);

      // first group and fill
      set_alloc(2'b11, 1'b1);
      #1 check_eq("first_addr", bus.rob_addr, 8'h10);
      tick();
      set_alloc(2'b00, 1'b0);
      #1 check_eq("first_count", count, 2);
      for (int n = 0; n < 7; n++) begin
         set_alloc(2'b11, 1'b1);
         tick();
      end
      set_alloc(2'b00, 1'b0);
      #1;
      check_eq("fill_count", count, 16);
      check_eq("fill_ready", bus.alloc_ready, 0);
      set_alloc(2'b11, 1'b0);
      tick();
      set_alloc(2'b00, 1'b0);
      #1;
      check_eq("full_hold_count", count, 16);
      check_eq("full_hold_tail", bus.rob_addr, 8'h00);

      // out-of-order writeback
      set_wb(0, 1, 1'b0);
      #1 check_eq("ooo_wait", bus.commit_valid, 0);
      tick();
      clear_wb();
      set_wb(2, 0, 1'b0);
      #1 check_eq("no_bypass", bus.commit_valid, 0);
      tick();
      clear_wb();
      #1;
      check_eq("ooo_commit", bus.commit_valid, 2'b11);
      check_eq("ooo_pc", bus.commit_pc, {pc_of(1), pc_of(0)});
      check_eq("ooo_dst", bus.commit_dst, {6'd1, 6'd0});
      tick();
      check_eq("ooo_count", count, 14);
      check_eq("ooo_ready", bus.alloc_ready, 1);
      check_eq("ooo_idle", bus.commit_valid, 0);

      // exception isolation
      set_wb(1, 2, 1'b1);
      set_wb(3, 3, 1'b0);
      tick();
      clear_wb();
      #1;
      check_eq("exc_valid", bus.commit_valid, 2'b01);
      check_eq("exc_flag", bus.commit_exc, 2'b01);
      check_eq("exc_pc", bus.commit_pc[31:0], pc_of(2));
      tick();
      check_eq("exc_next_valid", bus.commit_valid, 2'b01);
      check_eq("exc_next_flag", bus.commit_exc, 2'b00);
      check_eq("exc_next_pc", bus.commit_pc[31:0], pc_of(3));
      tick();
      check_eq("exc_count", count, 12);

      // drain remaining entries 4..15
      for (int e = 4; e < 16; e += 4) begin
         for (int p = 0; p < FN; p++) set_wb(p, e + p, 1'b0);
         tick();
         clear_wb();
      end
      for (int n = 0; n < 20 && count != 0; n++) tick();
      check_eq("drain_count", count, 0);
      check_eq("drain_tail", bus.rob_addr, 8'h00);

      // wrap: second lap of the pointers
      for (int n = 0; n < 7; n++) begin
         set_alloc(2'b11, 1'b1);
         tick();
      end
      set_alloc(2'b10, 1'b1);
      #1 check_eq("compact_addr", bus.rob_addr, 8'hEE);
      tick();
      set_alloc(2'b00, 1'b0);
      #1;
      check_eq("wrap_count15", count, 15);
      check_eq("wrap_ready0", bus.alloc_ready, 0);
      for (int p = 0; p < FN; p++) set_wb(p, p, 1'b0);
      tick();
      clear_wb();
      #1;
      check_eq("wrap_commit_a", bus.commit_valid, 2'b11);
      check_eq("wrap_pc_a", bus.commit_pc, {pc_of(17), pc_of(16)});
      tick();
      check_eq("wrap_commit_b", bus.commit_valid, 2'b11);
      check_eq("wrap_pc_b", bus.commit_pc, {pc_of(19), pc_of(18)});
      tick();
      check_eq("wrap_count11", count, 11);
      check_eq("wrap_ready1", bus.alloc_ready, 1);
      set_alloc(2'b11, 1'b1);
      #1 check_eq("wrap_addr", bus.rob_addr, 8'h0F);
      tick();
      set_alloc(2'b00, 1'b0);
      #1;
      check_eq("wrap_count13", count, 13);
      check_eq("wrap_tail", bus.rob_addr, 8'h11);
      set_alloc(2'b11, 1'b1);
      tick();
      set_alloc(2'b00, 1'b0);
      #1;
      check_eq("wrap_full_count", count, 15);
      check_eq("wrap_full_ready", bus.alloc_ready, 0);

      // flush from a nearly full buffer
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check_eq("flush1_count", count, 0);
      check_eq("flush1_tail", bus.rob_addr, 8'h00);

      // five busy entries, entry 0 done, then flush with concurrent alloc
      base = seq;
      set_alloc(2'b11, 1'b1);
      tick();
      set_alloc(2'b11, 1'b1);
      tick();
      set_alloc(2'b10, 1'b1);
      tick();
      set_alloc(2'b00, 1'b0);
      #1 check_eq("five_count", count, 5);
      set_wb(0, 0, 1'b0);
      tick();
      clear_wb();
      #1;
      check_eq("pre_flush_commit", bus.commit_valid, 2'b01);
      check_eq("pre_flush_pc", bus.commit_pc[31:0], pc_of(base));
      flush = 1'b1;
      set_alloc(2'b11, 1'b0);
      #1;
      check_eq("flush_cycle_commit", bus.commit_valid, 2'b01);
      check_eq("flush_cycle_addr", bus.rob_addr, 8'h65);
      tick();
      flush = 1'b0;
      #1;
      check_eq("flush2_count", count, 0);
      check_eq("flush2_commit", bus.commit_valid, 0);
      check_eq("flush2_ready", bus.alloc_ready, 1);
      check_eq("flush2_addr", bus.rob_addr, 8'h10);
      set_alloc(2'b00, 1'b0);

      // normal operation after flush
      base = seq;
      set_alloc(2'b11, 1'b1);
      tick();
      set_alloc(2'b00, 1'b0);
      set_wb(0, 0, 1'b0);
      set_wb(1, 1, 1'b0);
      tick();
      clear_wb();
      #1;
      check_eq("post_flush_commit", bus.commit_valid, 2'b11);
      check_eq("post_flush_pc", bus.commit_pc, {pc_of(base + 1), pc_of(base)});
      check_eq("post_flush_count", count, 2);
`ifdef ROB_PERF_CNT_EN
      check_eq("perf_flush_cnt", perf_flush_cnt, 2);
`endif
      tick();
      check_eq("final_count", count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
